polar_to_cart_cordic: RTL and testbench

//  Iterative CORDIC (rotation mode): converts polar (r, theta in degrees, first quadrant)
//  to Cartesian (x, y), 8-bit unsigned each. Inverse of the rectangular->polar path.

---
 rtl/polar_to_cart_cordic.sv | 216 +++++++++++++++++++++
 tb/tb_polar_to_cart_cordic.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/polar_to_cart_cordic.sv
// -----------------------------------------------------------------------------
// polar_to_cart_cordic
//   Iterative rotation-mode CORDIC that turns a first-quadrant polar input
//   (r, theta in whole degrees) into unsigned 8-bit Cartesian x/y.
//   One conversion in flight; valid/ready handshake on both sides.
//
// Parameters
//   ITER  CORDIC iterations, 8..12 (angle table holds 12 entries)
//   W     signed x/y datapath width, Q9.8 plus sign
//
// Ports
//   clk        clock
//   rst_n      asynchronous active-low reset
//   ena        global enable; low freezes FSM, counter and datapath
//   in_valid   r_in/theta_in valid
//   in_ready   high only in IDLE with ena=1 (combinational)
//   r_in       magnitude, unsigned
//   theta_in   angle in degrees 0..90, larger values clamp to 90
//   out_valid  x_out/y_out valid, held until out_ready
//   out_ready  consumer accepts result
//   x_out      r*cos(theta), saturated 0..255
//   y_out      r*sin(theta), saturated 0..255
//
// Build option
//   P2C_ROUND_EN  defined: round half up on the Q8.8 -> integer step.
//                 undefined: truncate toward -inf (no rounding adder).
//
// State table
//   IDLE | waiting for an input handshake; in_ready = ena
//   ROT  | one CORDIC micro-rotation per enabled clock, cnt = iteration
//   DONE | first cycle loads x_out/y_out; then out_valid held until out_ready
// -----------------------------------------------------------------------------
module polar_to_cart_cordic #(
  parameter int ITER = 10,
  parameter int W    = 18
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] r_in,
  input  logic [7:0] theta_in,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] x_out,
  output logic [7:0] y_out
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ROT  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam int ZW = 17;

  localparam logic [3:0]          CNT_LAST = 4'(ITER - 1);
  localparam logic [15:0]         INV_K    = 16'd39797;  // 256*256/1.64676
  localparam logic signed [W:0]   RND_HALF = (W+1)'(128);
  localparam logic signed [W:0]   SAT_MAX  = (W+1)'(255);

  logic [1:0]            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic signed [W-1:0]   x_q, x_d;
  logic signed [W-1:0]   y_q, y_d;
  logic signed [ZW-1:0]  z_q, z_d;
  logic                  out_valid_q, out_valid_d;
  logic [7:0]            x_out_q, x_out_d;
  logic [7:0]            y_out_q, y_out_d;

  logic [23:0]           r_scaled;
  logic [7:0]            theta_sat;
  logic signed [W-1:0]   x_cap;
  logic signed [ZW-1:0]  z_cap;
  logic signed [W-1:0]   x_sh, y_sh;
  logic signed [ZW-1:0]  atan_i;
  logic                  z_neg;
  logic [7:0]            x_sat, y_sat;

  function automatic logic signed [ZW-1:0] atan_lut(input logic [3:0] idx);
    logic signed [ZW-1:0] v;
    case (idx)
      4'd0:    v = 17'sd11520;
      4'd1:    v = 17'sd6801;
      4'd2:    v = 17'sd3593;
      4'd3:    v = 17'sd1824;
      4'd4:    v = 17'sd916;
      4'd5:    v = 17'sd458;
      4'd6:    v = 17'sd229;
      4'd7:    v = 17'sd115;
      4'd8:    v = 17'sd57;
      4'd9:    v = 17'sd29;
      4'd10:   v = 17'sd14;
      4'd11:   v = 17'sd7;
      default: v = 17'sd0;
    endcase
    return v;
  endfunction

  // Q9.8 -> unsigned 8-bit with clamp; rounding offset is added only when
  // the rounding build is selected.
  function automatic logic [7:0] to_u8(input logic signed [W-1:0] v);
    logic signed [W:0] adj;
    logic signed [W:0] whole;
    logic [7:0]        res;
`ifdef P2C_ROUND_EN
    adj = {v[W-1], v} + RND_HALF;
`else
    adj = {v[W-1], v};
`endif
    whole = adj >>> 8;
    if (whole[W])
      res = 8'd0;
    else if (whole > SAT_MAX)
      res = 8'd255;
    else
      res = whole[7:0];
    return res;
  endfunction

  // Pre-divide r by the CORDIC gain so the rotated vector ends at length r.
  assign r_scaled  = r_in * INV_K;
  assign theta_sat = (theta_in > 8'd90) ? 8'd90 : theta_in;
  assign x_cap     = $signed({{(W-16){1'b0}}, r_scaled[23:8]});
  assign z_cap     = $signed({1'b0, theta_sat, 8'h00});

  assign x_sh   = x_q >>> cnt_q;
  assign y_sh   = y_q >>> cnt_q;
  assign atan_i = atan_lut(cnt_q);
  assign z_neg  = z_q[ZW-1];

  assign x_sat = to_u8(x_q);
  assign y_sat = to_u8(y_q);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    x_d         = x_q;
    y_d         = y_q;
    z_d         = z_q;
    out_valid_d = out_valid_q;
    x_out_d     = x_out_q;
    y_out_d     = y_out_q;

    if (ena) begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            x_d     = x_cap;
            y_d     = '0;
            z_d     = z_cap;
            cnt_d   = '0;
            state_d = S_ROT;
          end
        end
        S_ROT: begin
          if (z_neg) begin
            x_d = x_q + y_sh;
            y_d = y_q - x_sh;
            z_d = z_q + atan_i;
          end else begin
            x_d = x_q - y_sh;
            y_d = y_q + x_sh;
            z_d = z_q - atan_i;
          end
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == CNT_LAST)
            state_d = S_DONE;
        end
        S_DONE: begin
          // The final x/y only settle on the DONE entry edge, so the output
          // registers are loaded one clock into DONE.
          if (!out_valid_q) begin
            x_out_d     = x_sat;
            y_out_d     = y_sat;
            out_valid_d = 1'b1;
          end else if (out_ready) begin
            out_valid_d = 1'b0;
            state_d     = S_IDLE;
          end
        end
        default: begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      out_valid_q <= 1'b0;
      x_out_q     <= '0;
      y_out_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      x_q         <= x_d;
      y_q         <= y_d;
      z_q         <= z_d;
      out_valid_q <= out_valid_d;
      x_out_q     <= x_out_d;
      y_out_q     <= y_out_d;
    end
  end

  assign in_ready  = ena && (state_q == S_IDLE);
  assign out_valid = out_valid_q;
  assign x_out     = x_out_q;
  assign y_out     = y_out_q;

endmodule

// File: tb/tb_polar_to_cart_cordic.sv
module tb_polar_to_cart_cordic;

`ifdef P2C_ROUND_EN
  localparam int TOL = 1;
`else
  localparam int TOL = 2;
`endif

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] r_in;
  logic [7:0] theta_in;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] x_out;
  logic [7:0] y_out;

  int checks = 0;
  int errors = 0;

  polar_to_cart_cordic #(.ITER(10), .W(18)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .r_in      (r_in),
    .theta_in  (theta_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .x_out     (x_out),
    .y_out     (y_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp, input int tol);
    checks++;
    if (obs < exp - tol || obs > exp + tol) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, obs, exp, tol);
    end
  endtask

  // Present an input and wait for the accepting edge; returns on the
  // falling edge right after the accept.
  task automatic start(input int r, input int th);
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    r_in     = 8'(r);
    theta_in = 8'(th);
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("in_ready_timeout", 0, 1, 0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Counts rising edges since the accept until out_valid is seen.
  task automatic wait_valid(input int lat0, output int lat);
    lat = lat0;
    for (int k = 0; k < 100; k++) begin
      if (out_valid) break;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (!out_valid) check("out_valid_timeout", 0, 1, 0);
  endtask

  task automatic finish_out();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("ov_clear", int'(out_valid), 0, 0);
    check("in_ready_after", int'(in_ready), 1, 0);
  endtask

  int vr [6] = '{100, 100, 200, 255,   0,  50};
  int vt [6] = '{  0,  90,  45,  30,  60, 200};
  int vx [6] = '{100,   0, 141, 221,   0,   0};
  int vy [6] = '{  0, 100, 141, 128,   0,  50};

  initial begin
    int lat;
    rst_n     = 1'b0;
    ena       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    r_in      = '0;
    theta_in  = '0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", int'(out_valid), 0, 0);
    check("rst_x_out", int'(x_out), 0, 0);
    check("rst_y_out", int'(y_out), 0, 0);
    check("rst_in_ready", int'(in_ready), 1, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      start(vr[i], vt[i]);
      check("rot_in_ready", int'(in_ready), 0, 0);
      wait_valid(0, lat);
      check($sformatf("lat_%0d", i), lat, 11, 0);
      check($sformatf("x_%0d_%0d", vr[i], vt[i]), int'(x_out), vx[i], (vr[i] == 0) ? 0 : TOL);
      check($sformatf("y_%0d_%0d", vr[i], vt[i]), int'(y_out), vy[i], (vr[i] == 0) ? 0 : TOL);
      finish_out();
    end

    // Backpressure: result and handshake state held while out_ready is low.
    start(200, 45);
    wait_valid(0, lat);
    for (int k = 0; k < 5; k++) begin
      check("bp_out_valid", int'(out_valid), 1, 0);
      check("bp_in_ready", int'(in_ready), 0, 0);
      check("bp_x", int'(x_out), 141, TOL);
      check("bp_y", int'(y_out), 141, TOL);
      @(negedge clk);
    end
    finish_out();
    check("keep_x", int'(x_out), 141, TOL);
    check("keep_y", int'(y_out), 141, TOL);

    // ena low for 3 clocks mid-rotation adds exactly 3 to the latency.
    start(255, 30);
    repeat (3) @(negedge clk);
    ena = 1'b0;
    check("ena_in_ready", int'(in_ready), 0, 0);
    repeat (3) @(negedge clk);
    ena = 1'b1;
    wait_valid(6, lat);
    check("ena_lat", lat, 14, 0);
    check("ena_x", int'(x_out), 221, TOL);
    check("ena_y", int'(y_out), 128, TOL);

    // ena low in DONE blocks the output handshake.
    ena       = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("ena_done_ov", int'(out_valid), 1, 0);
    out_ready = 1'b0;
    ena       = 1'b1;
    finish_out();

    // Reset pulse mid-rotation discards the conversion.
    start(255, 30);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ov", int'(out_valid), 0, 0);
    check("mid_rst_x", int'(x_out), 0, 0);
    check("mid_rst_y", int'(y_out), 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("post_rst_ov", int'(out_valid), 0, 0);
    check("post_rst_in_ready", int'(in_ready), 1, 0);

    start(100, 0);
    wait_valid(0, lat);
    check("recover_lat", lat, 11, 0);
    check("recover_x", int'(x_out), 100, TOL);
    check("recover_y", int'(y_out), 0, TOL);
    finish_out();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
